// File: rtl/load_sequencer.sv
// Load sequencer: issues one read to byte-addressed data memory, waits a fixed
// latency, then extracts and sign/zero-extends the low field for the register file.
module load_sequencer #(
  parameter int unsigned MEM_LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] addr,
  input  logic [1:0]  load_control_sign,
  input  logic        zero_ext,
  output logic [31:0] mem_addr,
  output logic        mem_rd,
  input  logic [31:0] mem_data_in,
  output logic [31:0] load_out,
  output logic        busy,
  output logic        done,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);

  localparam logic [1:0] LCS_BYTE = 2'b10;
  localparam logic [1:0] LCS_HALF = 2'b11;

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  cnt;
  logic [3:0]  cnt_nxt;
  logic [1:0]  lat_sign;
  logic        lat_zext;
  logic        accept;
  logic        capture;
  logic [31:0] extracted;

  // Handshake: start is a request with no separate ready; it is taken on any
  // rising edge where the unit is not busy (IDLE or DONE). While busy, start is
  // dropped rather than queued, so the requester must hold or retry it.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    capture   = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          accept    = 1'b1;
          cnt_nxt   = CNT_INIT;
          state_nxt = S_WAIT;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt != 4'd0) begin
          cnt_nxt = cnt - 4'd1;
        end else begin
          capture   = 1'b1;
          state_nxt = S_DONE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  // Always the low field: the store side writes the low field, so address low
  // bits never pick a lane here.
  always_comb begin
    extracted = mem_data_in;
    case (lat_sign)
      LCS_BYTE: extracted = {{24{~lat_zext & mem_data_in[7]}},  mem_data_in[7:0]};
      LCS_HALF: extracted = {{16{~lat_zext & mem_data_in[15]}}, mem_data_in[15:0]};
      default:  extracted = mem_data_in;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      cnt      <= 4'd0;
      mem_addr <= 32'd0;
      load_out <= 32'd0;
      lat_sign <= 2'b00;
      lat_zext <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        mem_addr <= addr;
        lat_sign <= load_control_sign;
        lat_zext <= zero_ext;
      end
      if (capture) begin
        load_out <= extracted;
      end
    end
  end

  // Strobes decode straight from the state register so reset clears them at once.
  assign mem_rd    = (state == S_WAIT);
  assign busy      = (state == S_WAIT);
  assign done      = (state == S_DONE);
  assign state_dbg = state;

endmodule

// File: tb/tb_load_sequencer.sv
// Directed bench for load_sequencer: a MEM_LATENCY=2 instance for the main
// sequence and a MEM_LATENCY=1 instance for the short-latency build.
module tb_load_sequencer;

  logic        clk;
  logic        reset;

  logic        start;
  logic [31:0] addr;
  logic [1:0]  sign;
  logic        zext;
  logic [31:0] data;
  logic [31:0] mem_addr;
  logic        mem_rd;
  logic [31:0] load_out;
  logic        busy;
  logic        done;
  logic [1:0]  dbg;

  logic        start1;
  logic [31:0] addr1;
  logic [1:0]  sign1;
  logic        zext1;
  logic [31:0] data1;
  logic [31:0] mem_addr1;
  logic        mem_rd1;
  logic [31:0] load_out1;
  logic        busy1;
  logic        done1;
  logic [1:0]  dbg1;

  int checks = 0;
  int errors = 0;

  load_sequencer #(.MEM_LATENCY(2)) dut (
    .clk(clk), .reset(reset), .start(start), .addr(addr),
    .load_control_sign(sign), .zero_ext(zext), .mem_addr(mem_addr),
    .mem_rd(mem_rd), .mem_data_in(data), .load_out(load_out),
    .busy(busy), .done(done), .state_dbg(dbg)
  );

  load_sequencer #(.MEM_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .addr(addr1),
    .load_control_sign(sign1), .zero_ext(zext1), .mem_addr(mem_addr1),
    .mem_rd(mem_rd1), .mem_data_in(data1), .load_out(load_out1),
    .busy(busy1), .done(done1), .state_dbg(dbg1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete load on the latency-2 instance, with inputs disturbed after acceptance.
  task automatic run_load(input string tag, input logic [31:0] a, input logic [1:0] s,
                          input logic z, input logic [31:0] d, input logic [31:0] exp);
    logic [31:0] prev;
    prev  = load_out;
    start = 1'b1; addr = a; sign = s; zext = z; data = d;
    tick();
    start = 1'b0; addr = ~a; sign = ~s; zext = ~z;
    check({tag, " w1 mem_rd"}, {31'd0, mem_rd}, 32'd1);
    check({tag, " w1 busy"}, {31'd0, busy}, 32'd1);
    check({tag, " w1 done"}, {31'd0, done}, 32'd0);
    check({tag, " w1 mem_addr"}, mem_addr, a);
    check({tag, " w1 load_out held"}, load_out, prev);
    tick();
    check({tag, " w2 mem_rd"}, {31'd0, mem_rd}, 32'd1);
    check({tag, " w2 busy"}, {31'd0, busy}, 32'd1);
    check({tag, " w2 mem_addr"}, mem_addr, a);
    tick();
    check({tag, " done"}, {31'd0, done}, 32'd1);
    check({tag, " done busy"}, {31'd0, busy}, 32'd0);
    check({tag, " done mem_rd"}, {31'd0, mem_rd}, 32'd0);
    check({tag, " load_out"}, load_out, exp);
    data = 32'h5A5A_5A5A;
    tick();
    check({tag, " idle done"}, {31'd0, done}, 32'd0);
    check({tag, " idle load_out held"}, load_out, exp);
    check({tag, " idle mem_addr held"}, mem_addr, a);
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0; addr = 32'd0; sign = 2'b00; zext = 1'b0; data = 32'd0;
    start1 = 1'b0; addr1 = 32'd0; sign1 = 2'b00; zext1 = 1'b0; data1 = 32'd0;
    #3;
    check("reset mem_addr", mem_addr, 32'd0);
    check("reset mem_rd", {31'd0, mem_rd}, 32'd0);
    check("reset load_out", load_out, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    tick();
    tick();
    reset = 1'b1;
    tick();

    run_load("word", 32'h0000_0100, 2'b00, 1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    run_load("byte sx", 32'h0000_0104, 2'b10, 1'b0, 32'h1234_5680, 32'hFFFF_FF80);
    run_load("byte zx", 32'h0000_0105, 2'b10, 1'b1, 32'h1234_5680, 32'h0000_0080);
    run_load("half pos", 32'h0000_0108, 2'b11, 1'b0, 32'hAAAA_7FFF, 32'h0000_7FFF);
    run_load("half neg", 32'h0000_010A, 2'b11, 1'b0, 32'h0000_8001, 32'hFFFF_8001);
    run_load("word 01", 32'h0000_010C, 2'b01, 1'b1, 32'h8765_4321, 32'h8765_4321);

    // start held high, sign toggled during WAIT: one load every 3 cycles
    start = 1'b1; addr = 32'h0000_0400; sign = 2'b10; zext = 1'b0; data = 32'h1234_5680;
    tick();
    check("b2b1 w1 busy", {31'd0, busy}, 32'd1);
    check("b2b1 w1 done", {31'd0, done}, 32'd0);
    sign = 2'b00;
    tick();
    check("b2b1 w2 busy", {31'd0, busy}, 32'd1);
    check("b2b1 w2 done", {31'd0, done}, 32'd0);
    sign = 2'b11;
    tick();
    check("b2b1 done", {31'd0, done}, 32'd1);
    check("b2b1 load_out", load_out, 32'hFFFF_FF80);
    data = 32'h0000_8001;
    tick();
    check("b2b2 w1 busy", {31'd0, busy}, 32'd1);
    check("b2b2 w1 done", {31'd0, done}, 32'd0);
    check("b2b2 w1 load_out held", load_out, 32'hFFFF_FF80);
    sign = 2'b10;
    tick();
    check("b2b2 w2 done", {31'd0, done}, 32'd0);
    tick();
    check("b2b2 done", {31'd0, done}, 32'd1);
    check("b2b2 load_out", load_out, 32'hFFFF_8001);
    sign = 2'b00; data = 32'hA5A5_A5A5;
    tick();
    check("b2b3 w1 busy", {31'd0, busy}, 32'd1);
    sign = 2'b11;
    tick();
    check("b2b3 w2 done", {31'd0, done}, 32'd0);
    tick();
    check("b2b3 done", {31'd0, done}, 32'd1);
    check("b2b3 load_out", load_out, 32'hA5A5_A5A5);
    start = 1'b0;
    tick();
    check("b2b end done", {31'd0, done}, 32'd0);
    check("b2b end busy", {31'd0, busy}, 32'd0);

    // asynchronous reset in the middle of WAIT
    start = 1'b1; addr = 32'h0000_0200; sign = 2'b00; zext = 1'b0; data = 32'h1111_1111;
    tick();
    start = 1'b0;
    check("rst pre busy", {31'd0, busy}, 32'd1);
    #2 reset = 1'b0;
    #1;
    check("rst async mem_rd", {31'd0, mem_rd}, 32'd0);
    check("rst async busy", {31'd0, busy}, 32'd0);
    check("rst async done", {31'd0, done}, 32'd0);
    check("rst async mem_addr", mem_addr, 32'd0);
    check("rst async load_out", load_out, 32'd0);
    tick();
    tick();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rst after done", {31'd0, done}, 32'd0);
      check("rst after busy", {31'd0, busy}, 32'd0);
    end
    run_load("post rst", 32'h0000_0300, 2'b00, 1'b0, 32'hCAFE_F00D, 32'hCAFE_F00D);

    // MEM_LATENCY=1 instance: capture on the edge right after acceptance
    start1 = 1'b1; addr1 = 32'h0000_0040; sign1 = 2'b10; zext1 = 1'b1; data1 = 32'h0000_00FF;
    tick();
    start1 = 1'b0;
    check("l1 wait mem_rd", {31'd0, mem_rd1}, 32'd1);
    check("l1 wait busy", {31'd0, busy1}, 32'd1);
    check("l1 wait mem_addr", mem_addr1, 32'h0000_0040);
    check("l1 wait done", {31'd0, done1}, 32'd0);
    data1 = 32'h0000_0081; sign1 = 2'b00;
    tick();
    check("l1 done", {31'd0, done1}, 32'd1);
    check("l1 load_out", load_out1, 32'h0000_0081);
    check("l1 done busy", {31'd0, busy1}, 32'd0);
    tick();
    check("l1 idle done", {31'd0, done1}, 32'd0);
    check("l1 idle busy", {31'd0, busy1}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
